fifo16: RTL and testbench

FIFO16 -- requirements
Module: fifo16

---
 rtl/fifo16.sv | 85 ++++++++
 tb/tb_fifo16.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo16.sv
// fifo16: single-clock synchronous FIFO with registered read data,
// occupancy counter and programmable almost-full / almost-empty flags.
// Depth is 2^BUF_WIDTH entries; the counter is one bit wider than the
// pointers so that "full" (count == DEPTH) is distinct from "empty".
module fifo16 #(
  parameter int BUF_WIDTH  = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] buf_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [BUF_WIDTH:0]    uH,
  input  logic [BUF_WIDTH:0]    uL,
  output logic [DATA_WIDTH-1:0] buf_out,
  output logic                  buf_empty,
  output logic                  buf_full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [BUF_WIDTH:0]    fifo_counter
);

  localparam int                 DEPTH   = 1 << BUF_WIDTH;
  localparam logic [BUF_WIDTH:0] DEPTH_C = (BUF_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [BUF_WIDTH-1:0]  wr_ptr;
  logic [BUF_WIDTH-1:0]  rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Almost-full threshold DEPTH - margin, clamped at zero so an oversized
  // margin keeps the flag permanently asserted instead of wrapping.
  function automatic logic [BUF_WIDTH:0] af_threshold(input logic [BUF_WIDTH:0] margin);
    if (margin > DEPTH_C)
      return '0;
    else
      return DEPTH_C - margin;
  endfunction

  // Status flags decode only the registered counter.
  always_comb begin
    buf_empty    = (fifo_counter == '0);
    buf_full     = (fifo_counter == DEPTH_C);
    almost_full  = (fifo_counter >= af_threshold(uH));
    almost_empty = (fifo_counter <= uL);
  end

  // Accept a request only when the FIFO can honour it; at full a paired
  // write is dropped, at empty a paired read is dropped.
  always_comb begin
    wr_acc = wr_en && !buf_full;
    rd_acc = rd_en && !buf_empty;
  end

  // Storage array: no reset, writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst && wr_acc)
      mem[wr_ptr] <= buf_in;
  end

  // Pointers, occupancy counter and registered read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_counter <= '0;
      buf_out      <= '0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) begin
        rd_ptr  <= rd_ptr + 1'b1;
        buf_out <= mem[rd_ptr];
      end
      case ({wr_acc, rd_acc})
        2'b10:   fifo_counter <= fifo_counter + 1'b1;
        2'b01:   fifo_counter <= fifo_counter - 1'b1;
        default: fifo_counter <= fifo_counter;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo16.sv
// tb_fifo16: directed self-checking bench for fifo16 (depth 16, 4-bit data).
module tb_fifo16;

  logic       clk;
  logic       rst;
  logic [3:0] buf_in;
  logic       wr_en;
  logic       rd_en;
  logic [4:0] uH;
  logic [4:0] uL;
  logic [3:0] buf_out;
  logic       buf_empty;
  logic       buf_full;
  logic       almost_full;
  logic       almost_empty;
  logic [4:0] fifo_counter;

  int checks = 0;
  int errors = 0;

  fifo16 #(.BUF_WIDTH(4), .DATA_WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .buf_in       (buf_in),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .uH           (uH),
    .uL           (uL),
    .buf_out      (buf_out),
    .buf_empty    (buf_empty),
    .buf_full     (buf_full),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_counter (fifo_counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] d);
    wr_en  = 1'b1;
    buf_in = d;
    step();
    wr_en  = 1'b0;
  endtask

  task automatic read_word();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; buf_in = '0; uH = 5'd2; uL = 5'd3;
    #2;
    checks++; if (fifo_counter !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_counter); end
    checks++; if (buf_out !== 4'd0) begin errors++; $display("FAIL reset_out: got %0d expected 0", buf_out); end
    checks++; if ({buf_empty, buf_full, almost_empty, almost_full} !== 4'b1010) begin errors++; $display("FAIL reset_flags: got %b expected 1010", {buf_empty, buf_full, almost_empty, almost_full}); end
    step();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_simul_basic();
    write_word(4'd1);
    wr_en = 1'b1; rd_en = 1'b1; buf_in = 4'd2;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (buf_out !== 4'd1) begin errors++; $display("FAIL simul_out: got %0d expected 1", buf_out); end
    checks++; if (fifo_counter !== 5'd1) begin errors++; $display("FAIL simul_count: got %0d expected 1", fifo_counter); end
    read_word();
    checks++; if (buf_out !== 4'd2) begin errors++; $display("FAIL simul_second: got %0d expected 2", buf_out); end
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL simul_empty: got %0d expected 1", buf_empty); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 16; i++) begin
      write_word(4'(i));
      checks++; if (fifo_counter !== 5'(i + 1)) begin errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, fifo_counter, i + 1); end
      checks++; if (almost_full !== ((i + 1) >= 14)) begin errors++; $display("FAIL fill_af[%0d]: got %0d expected %0d", i, almost_full, (i + 1) >= 14); end
    end
    checks++; if (buf_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %0d expected 1", buf_full); end
    write_word(4'd9);
    checks++; if (fifo_counter !== 5'd16) begin errors++; $display("FAIL fill_overflow: got %0d expected 16", fifo_counter); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 16; i++) begin
      read_word();
      checks++; if (buf_out !== 4'(i)) begin errors++; $display("FAIL drain_out[%0d]: got %0d expected %0d", i, buf_out, i); end
      checks++; if (almost_empty !== ((15 - i) <= 3)) begin errors++; $display("FAIL drain_ae[%0d]: got %0d expected %0d", i, almost_empty, (15 - i) <= 3); end
    end
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0d expected 1", buf_empty); end
    read_word();
    checks++; if (buf_out !== 4'd15) begin errors++; $display("FAIL drain_underflow_out: got %0d expected 15", buf_out); end
    checks++; if (fifo_counter !== 5'd0) begin errors++; $display("FAIL drain_underflow_cnt: got %0d expected 0", fifo_counter); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_q [16];
    for (int i = 0; i < 16; i++) write_word(4'(i));
    for (int i = 0; i < 4; i++) begin
      read_word();
      checks++; if (buf_out !== 4'(i)) begin errors++; $display("FAIL wrap_pre[%0d]: got %0d expected %0d", i, buf_out, i); end
    end
    for (int i = 0; i < 4; i++) write_word(4'(10 + i));
    checks++; if (fifo_counter !== 5'd16) begin errors++; $display("FAIL wrap_count: got %0d expected 16", fifo_counter); end
    for (int i = 0; i < 12; i++) exp_q[i] = 4'(i + 4);
    for (int i = 0; i < 4; i++) exp_q[12 + i] = 4'(10 + i);
    for (int i = 0; i < 16; i++) begin
      read_word();
      checks++; if (buf_out !== exp_q[i]) begin errors++; $display("FAIL wrap_out[%0d]: got %0d expected %0d", i, buf_out, exp_q[i]); end
    end
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %0d expected 1", buf_empty); end
  endtask

  task automatic test_full_simul();
    for (int i = 0; i < 16; i++) write_word(4'(15 - i));
    wr_en = 1'b1; rd_en = 1'b1; buf_in = 4'd7;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (fifo_counter !== 5'd15) begin errors++; $display("FAIL fullsim_count: got %0d expected 15", fifo_counter); end
    checks++; if (buf_full !== 1'b0) begin errors++; $display("FAIL fullsim_full: got %0d expected 0", buf_full); end
    checks++; if (buf_out !== 4'd15) begin errors++; $display("FAIL fullsim_out: got %0d expected 15", buf_out); end
    for (int i = 0; i < 15; i++) begin
      read_word();
      checks++; if (buf_out !== 4'(14 - i)) begin errors++; $display("FAIL fullsim_drain[%0d]: got %0d expected %0d", i, buf_out, 14 - i); end
    end
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL fullsim_lost: got empty=%0d expected 1", buf_empty); end
  endtask

  task automatic test_empty_simul();
    wr_en = 1'b1; rd_en = 1'b1; buf_in = 4'd9;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    checks++; if (fifo_counter !== 5'd1) begin errors++; $display("FAIL emptysim_count: got %0d expected 1", fifo_counter); end
    checks++; if (buf_out !== 4'd0) begin errors++; $display("FAIL emptysim_out: got %0d expected 0", buf_out); end
    read_word();
    checks++; if (buf_out !== 4'd9) begin errors++; $display("FAIL emptysim_data: got %0d expected 9", buf_out); end
  endtask

  task automatic test_thresholds();
    uH = 5'd20;
    #1;
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL thr_uh_big: got %0d expected 1", almost_full); end
    uH = 5'd2; uL = 5'd0;
    #1;
    checks++; if ({almost_full, almost_empty} !== 2'b01) begin errors++; $display("FAIL thr_empty_ul0: got %b expected 01", {almost_full, almost_empty}); end
    write_word(4'd3);
    checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL thr_one_ul0: got %0d expected 0", almost_empty); end
    uL = 5'd3;
    read_word();
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) write_word(4'(6 + i));
    read_word();
    write_word(4'd11);
    checks++; if (fifo_counter !== 5'd5 || buf_out !== 4'd6) begin errors++; $display("FAIL arst_pre: got cnt=%0d out=%0d expected cnt=5 out=6", fifo_counter, buf_out); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (fifo_counter !== 5'd0) begin errors++; $display("FAIL arst_count: got %0d expected 0", fifo_counter); end
    checks++; if (buf_empty !== 1'b1) begin errors++; $display("FAIL arst_empty: got %0d expected 1", buf_empty); end
    checks++; if (buf_out !== 4'd0) begin errors++; $display("FAIL arst_out: got %0d expected 0", buf_out); end
    wr_en = 1'b1; buf_in = 4'd5;
    step();
    wr_en = 1'b0;
    checks++; if (fifo_counter !== 5'd0) begin errors++; $display("FAIL arst_hold: got %0d expected 0", fifo_counter); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    write_word(4'd12);
    read_word();
    checks++; if (buf_out !== 4'd12 || fifo_counter !== 5'd0) begin errors++; $display("FAIL arst_resume: got out=%0d cnt=%0d expected out=12 cnt=0", buf_out, fifo_counter); end
  endtask

  initial begin
    test_reset();
    test_simul_basic();
    test_fill();
    test_drain();
    test_wrap();
    test_full_simul();
    test_empty_simul();
    test_thresholds();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
